// File: rtl/shake_reject_sampler.sv
// rtl/shake_reject_sampler.sv - unpacks SHAKE256 words into 24-bit candidates and rejection-samples them
// Accepted candidates stream out; force_done ends the upstream squeeze once the request is met.
module shake_reject_sampler #(
  parameter int          WIN    = 32,
  parameter int          CW     = 24,
  parameter int unsigned THRESH = 32'd16767881,
  parameter int          CNT_W  = 16,
  parameter int          BUF_W  = WIN + CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_req,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIN-1:0]   din,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CW-1:0]    dout,
  output logic             busy,
  output logic             done,
  output logic             force_done
);

  localparam int              FILL_W   = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] CW_F   = FILL_W'(CW);
  localparam logic [FILL_W-1:0] WIN_F  = FILL_W'(WIN);
  localparam logic [CW-1:0]   THRESH_C = CW'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   num_req_q;
  logic [CNT_W-1:0]   acc_cnt;
  logic [FILL_W-1:0]  fill;
  logic [BUF_W-1:0]   bit_buf;

  logic               in_run;
  logic               pending;
  logic               word_hs;
  logic               extract_en;
  logic [CW-1:0]      cand;
  logic               reject;
  logic               out_free;
  logic               load;
  logic               shift_out;
  logic               last_hs;

  // Fill (fill < CW) and extraction (fill >= CW) are disjoint, so the buffer
  // never shifts in and out in the same cycle.
  always_comb begin
    in_run     = (state_q == S_RUN);
    pending    = (acc_cnt < num_req_q);
    din_ready  = in_run && (fill < CW_F) && pending;
    word_hs    = din_valid && din_ready;
    extract_en = in_run && (fill >= CW_F) && pending;
    cand       = bit_buf[CW-1:0];
    reject     = (cand >= THRESH_C);
    out_free   = !dout_valid || dout_ready;
    load       = extract_en && !reject && out_free;
    shift_out  = extract_en && (reject || out_free);
    last_hs    = in_run && dout_valid && dout_ready && (acc_cnt == num_req_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_req == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_hs) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_req_q  <= '0;
      acc_cnt    <= '0;
      fill       <= '0;
      bit_buf    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        num_req_q <= num_req;
        acc_cnt   <= '0;
        fill      <= '0;
        bit_buf   <= '0;
      end else begin
        // Bits above fill are always zero, so OR-ing the new word in places it at fill.
        if (word_hs) begin
          bit_buf <= bit_buf | (BUF_W'(din) << fill);
          fill    <= fill + WIN_F;
        end else if (shift_out) begin
          bit_buf <= bit_buf >> CW;
          fill    <= fill - CW_F;
        end
        if (load) begin
          acc_cnt <= acc_cnt + 1'b1;
        end
      end

      if (load) begin
        dout       <= cand;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign force_done = (state_q == S_DONE);

endmodule

// File: tb/tb_shake_reject_sampler.sv
// tb/tb_shake_reject_sampler.sv - scoreboard bench for shake_reject_sampler
// Word feeder and output monitor run on the falling edge; scenario tasks check inline.
module tb_shake_reject_sampler;

  localparam int WIN   = 32;
  localparam int CW    = 24;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_req = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [WIN-1:0]   din = '0;
  logic             dout_valid;
  logic             dout_ready = 1'b1;
  logic [CW-1:0]    dout;
  logic             busy;
  logic             done;
  logic             force_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] word_q[$];
  logic [23:0] exp_q[$];
  bit feed_en = 1'b0;
  bit din_hs = 1'b0;
  int words_used = 0;
  int out_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  shake_reject_sampler dut (
    .clk(clk), .rst(rst), .start(start), .num_req(num_req),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .busy(busy), .done(done), .force_done(force_done)
  );

  // Feeder + scoreboard: values at negedge+2 are what the next rising edge sees.
  always @(negedge clk) begin
    if (din_hs) begin
      word_q.delete(0);
      words_used++;
    end
    din_valid = feed_en && (word_q.size() > 0);
    din = din_valid ? word_q[0] : '0;
    #2;
    din_hs = din_valid && din_ready;
    if (done) done_cnt++;
    if (dout_valid && dout_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL out_unexpected: dout=%h, expected no output", dout);
      end else begin
        if (dout !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL out_value: dout=%h, expected %h", dout, exp_q[0]);
        end
        exp_q.delete(0);
      end
      out_cnt++;
    end
  end

  task automatic clear_bench();
    feed_en = 1'b0;
    word_q.delete();
    exp_q.delete();
    din_hs = 1'b0;
    words_used = 0;
    out_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic start_req(input int n);
    @(negedge clk);
    num_req = CNT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #3;
      if (done) seen = 1'b1;
    end
  endtask

  // Reference unpacking: concatenate queued words LSB-first, cut 24-bit chunks, keep those below 0xFFDB89.
  task automatic model_expect(input int n, output int need);
    logic [511:0] stream;
    logic [23:0]  c;
    int acc, idx, sz;
    stream = '0;
    sz = word_q.size();
    for (int i = 0; i < sz && i < 16; i++) stream[32*i +: 32] = word_q[i];
    acc = 0;
    idx = 0;
    while (acc < n && 24 * (idx + 1) <= 32 * sz && idx < 21) begin
      c = stream[24*idx +: 24];
      if (c < 24'hFFDB89) begin
        exp_q.push_back(c);
        acc++;
      end
      idx++;
    end
    need = (24 * idx + 31) / 32;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    tests_run++;
    if ({din_ready, dout_valid, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {din_ready,dout_valid,busy}=%b, expected 000", {din_ready, dout_valid, busy});
    end
    tests_run++;
    if ({done, force_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_done: {done,force_done}=%b, expected 00", {done, force_done});
    end
    tests_run++;
    if (dout !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_dout: dout=%h, expected 000000", dout);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    bit seen;
    clear_bench();
    word_q.push_back(32'h00000005);
    word_q.push_back(32'hDEADBEEF);
    exp_q.push_back(24'h000005);
    feed_en = 1'b1;
    start_req(1);
    wait_done(100, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL single_timeout: done=%b, expected 1 within 100 cycles", done);
    end
    tests_run++;
    if (force_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_force_done: force_done=%b, expected 1 with done", force_done);
    end
    @(negedge clk);
    #3;
    tests_run++;
    if ({done, force_done, busy, din_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_after: {done,force_done,busy,din_ready}=%b, expected 0000", {done, force_done, busy, din_ready});
    end
    tests_run++;
    if (out_cnt != 1 || words_used != 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL single_counts: outputs=%0d words=%0d left=%0d, expected 1 1 0", out_cnt, words_used, exp_q.size());
    end
  endtask

  task automatic test_packing();
    bit seen;
    clear_bench();
    word_q.push_back(32'h33221100);
    word_q.push_back(32'h77665544);
    word_q.push_back(32'hBBAA9988);
    word_q.push_back(32'h01020304);
    exp_q.push_back(24'h221100);
    exp_q.push_back(24'h554433);
    exp_q.push_back(24'h887766);
    exp_q.push_back(24'hBBAA99);
    feed_en = 1'b1;
    start_req(4);
    wait_done(100, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL packing_timeout: done=%b, expected 1 within 100 cycles", done);
    end
    tests_run++;
    if (out_cnt != 4 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL packing_count: outputs=%0d left=%0d, expected 4 0", out_cnt, exp_q.size());
    end
    tests_run++;
    if (words_used != 3) begin
      tests_failed++;
      $display("FAIL packing_words: consumed=%0d, expected 3", words_used);
    end
  endtask

  task automatic test_reject();
    bit seen;
    clear_bench();
    word_q.push_back(32'hFFFFFFFF);
    word_q.push_back(32'h00000000);
    word_q.push_back(32'h12345678);
    exp_q.push_back(24'h0000FF);
    feed_en = 1'b1;
    start_req(1);
    wait_done(100, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL reject_timeout: done=%b, expected 1 within 100 cycles", done);
    end
    tests_run++;
    if (out_cnt != 1 || words_used != 2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reject_counts: outputs=%0d words=%0d left=%0d, expected 1 2 0", out_cnt, words_used, exp_q.size());
    end
  endtask

  task automatic test_threshold();
    bit seen;
    clear_bench();
    // candidates 0xFFDB89 (reject), 0xFFDB88 (accept), 0x000001 (accept)
    word_q.push_back(32'h88FFDB89);
    word_q.push_back(32'h0001FFDB);
    word_q.push_back(32'h00000000);
    word_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(24'hFFDB88);
    exp_q.push_back(24'h000001);
    feed_en = 1'b1;
    start_req(2);
    wait_done(100, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL thresh_timeout: done=%b, expected 1 within 100 cycles", done);
    end
    tests_run++;
    if (out_cnt != 2 || words_used != 3 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL thresh_counts: outputs=%0d words=%0d left=%0d, expected 2 3 0", out_cnt, words_used, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int need;
    logic [23:0] first;
    clear_bench();
    word_q.push_back(32'h12345678);
    for (int i = 1; i < 12; i++) word_q.push_back((i == 3) ? 32'hFFFFFFFF : 32'($urandom));
    model_expect(8, need);
    feed_en = 1'b1;
    dout_ready = 1'b0;
    start_req(8);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (dout_valid) seen = 1'b1;
    end
    tests_run++;
    if (!seen || dout !== 24'h345678) begin
      tests_failed++;
      $display("FAIL bp_first: valid=%b dout=%h, expected 1 345678", dout_valid, dout);
    end
    first = dout;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      #3;
      tests_run++;
      if (dout_valid !== 1'b1 || dout !== first || din_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold: cycle %0d valid=%b dout=%h din_ready=%b, expected 1 %h 0", i, dout_valid, dout, din_ready, first);
      end
    end
    tests_run++;
    if (words_used != 2) begin
      tests_failed++;
      $display("FAIL bp_stall_words: consumed=%0d, expected 2", words_used);
    end
    @(negedge clk);
    dout_ready = 1'b1;
    wait_done(300, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL bp_timeout: done=%b, expected 1 within 300 cycles", done);
    end
    tests_run++;
    if (out_cnt != 8 || exp_q.size() != 0 || words_used != need) begin
      tests_failed++;
      $display("FAIL bp_counts: outputs=%0d left=%0d words=%0d, expected 8 0 %0d", out_cnt, exp_q.size(), words_used, need);
    end
  endtask

  task automatic test_num_req_zero();
    clear_bench();
    word_q.push_back(32'hABCDEF01);
    feed_en = 1'b1;
    start_req(0);
    #3;
    tests_run++;
    if ({done, force_done} !== 2'b11) begin
      tests_failed++;
      $display("FAIL zero_done: {done,force_done}=%b, expected 11", {done, force_done});
    end
    @(negedge clk);
    #3;
    tests_run++;
    if ({done, busy} !== 2'b00 || words_used != 0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL zero_after: {done,busy}=%b words=%0d dones=%0d, expected 00 0 1", {done, busy}, words_used, done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    bit seen;
    clear_bench();
    word_q.push_back(32'h11111111);
    word_q.push_back(32'h22222222);
    word_q.push_back(32'h33333333);
    word_q.push_back(32'h44444444);
    exp_q.push_back(24'h111111);
    exp_q.push_back(24'h222211);
    exp_q.push_back(24'h332222);
    feed_en = 1'b1;
    start_req(3);
    @(negedge clk);
    start = 1'b1;
    num_req = 16'd1;
    @(negedge clk);
    start = 1'b0;
    num_req = 16'd7;
    wait_done(100, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL restart_timeout: done=%b, expected 1 within 100 cycles", done);
    end
    repeat (3) @(negedge clk);
    #3;
    tests_run++;
    if (out_cnt != 3 || words_used != 3 || done_cnt != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_counts: outputs=%0d words=%0d dones=%0d busy=%b, expected 3 3 1 0", out_cnt, words_used, done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int need;
    logic [31:0] saved[$];
    clear_bench();
    for (int i = 0; i < 8; i++) word_q.push_back(32'($urandom));
    saved = word_q;
    model_expect(5, need);
    feed_en = 1'b1;
    start_req(5);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (dout_valid) seen = 1'b1;
    end
    #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({din_ready, dout_valid, busy, done, force_done} !== 5'b0 || dout !== 24'h0) begin
      tests_failed++;
      $display("FAIL midreset_async: {din_ready,dout_valid,busy,done,force_done}=%b dout=%h, expected 00000 000000",
               {din_ready, dout_valid, busy, done, force_done}, dout);
    end
    clear_bench();
    @(negedge clk);
    rst = 1'b1;
    word_q = saved;
    model_expect(5, need);
    feed_en = 1'b1;
    start_req(5);
    wait_done(200, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL midreset_timeout: done=%b, expected 1 within 200 cycles", done);
    end
    tests_run++;
    if (out_cnt != 5 || exp_q.size() != 0 || words_used != need) begin
      tests_failed++;
      $display("FAIL midreset_counts: outputs=%0d left=%0d words=%0d, expected 5 0 %0d", out_cnt, exp_q.size(), words_used, need);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_packing();
    test_reject();
    test_threshold();
    test_backpressure();
    test_num_req_zero();
    test_start_ignored();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule
